// File: rtl/mc_chroma_ref_fetch4x4.sv
// Chroma reference fetcher: reads the 7x7 integer support region of a 4x4 chroma block
// from the reference window SRAM and streams 7 column-aligned rows of 7 pixels.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module mc_chroma_ref_fetch4x4 #(
    parameter int unsigned PIXEL_WIDTH = `PIXEL_WIDTH,
    parameter int unsigned ROW_WORDS   = 8,
    parameter int unsigned AW          = 9
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start_i,
    input  logic [5:0]                 pos_x_i,
    input  logic [5:0]                 pos_y_i,
    input  logic [5:0]                 frac_i,
    output logic                       idle_o,
    output logic                       ref_rd_en_o,
    output logic [AW-1:0]              ref_rd_addr_o,
    input  logic [8*PIXEL_WIDTH-1:0]   ref_rd_data_i,
    output logic                       blk_start_o,
    output logic                       refuv_valid_o,
    output logic [PIXEL_WIDTH-1:0]     refuv_p0_o,
    output logic [PIXEL_WIDTH-1:0]     refuv_p1_o,
    output logic [PIXEL_WIDTH-1:0]     refuv_p2_o,
    output logic [PIXEL_WIDTH-1:0]     refuv_p3_o,
    output logic [PIXEL_WIDTH-1:0]     refuv_p4_o,
    output logic [PIXEL_WIDTH-1:0]     refuv_p5_o,
    output logic [PIXEL_WIDTH-1:0]     refuv_p6_o,
    output logic [5:0]                 frac_o,
    output logic                       done_o
);

    localparam int unsigned WORD_PIX = 8;
    localparam int unsigned DW       = WORD_PIX * PIXEL_WIDTH;
    localparam int unsigned ROWS     = 7;
    localparam int unsigned CAT_PIX  = 2 * WORD_PIX;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      row_q, row_d;
    logic [AW-1:0]   addr_d;
    logic            rd_en_d;
    logic            iss_end_d, iss_end_q;
    logic            iss_fin_d, iss_fin_q;
    logic            blk_d;
    logic            accept;
    logic            dual_q;
    logic [2:0]      off_q;

    logic            dat_vld_q;
    logic            dat_end_q;
    logic            dat_fin_q;
    logic [DW-1:0]   word0_q;
    logic [DW-1:0]   w0, w1;
    logic [PIXEL_WIDTH-1:0] cat   [CAT_PIX];
    logic [PIXEL_WIDTH-1:0] row_c [ROWS];

    assign accept = start_i & idle_o;

    // Next-state and next-cycle read issue; iss_end marks the read that completes a row.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        addr_d    = ref_rd_addr_o;
        rd_en_d   = 1'b0;
        iss_end_d = 1'b0;
        iss_fin_d = 1'b0;
        blk_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_FETCH0;
                    row_d     = 3'd0;
                    addr_d    = AW'(pos_y_i) * AW'(ROW_WORDS) + AW'(pos_x_i[5:3]);
                    rd_en_d   = 1'b1;
                    iss_end_d = (pos_x_i[2:0] < 3'd2);
                    blk_d     = 1'b1;
                end
            end
            S_FETCH0: begin
                if (dual_q) begin
                    state_d   = S_FETCH1;
                    addr_d    = ref_rd_addr_o + AW'(1);
                    rd_en_d   = 1'b1;
                    iss_end_d = 1'b1;
                    iss_fin_d = (row_q == 3'(ROWS - 1));
                end else if (row_q == 3'(ROWS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    row_d     = row_q + 3'd1;
                    addr_d    = ref_rd_addr_o + AW'(ROW_WORDS);
                    rd_en_d   = 1'b1;
                    iss_end_d = 1'b1;
                    iss_fin_d = (row_q == 3'(ROWS - 2));
                end
            end
            S_FETCH1: begin
                if (row_q == 3'(ROWS - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_FETCH0;
                    row_d   = row_q + 3'd1;
                    addr_d  = ref_rd_addr_o + AW'(ROW_WORDS - 1);
                    rd_en_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (done_o) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, read port and block-level registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            row_q         <= 3'd0;
            idle_o        <= 1'b1;
            ref_rd_en_o   <= 1'b0;
            ref_rd_addr_o <= '0;
            iss_end_q     <= 1'b0;
            iss_fin_q     <= 1'b0;
            blk_start_o   <= 1'b0;
            dual_q        <= 1'b0;
            off_q         <= 3'd0;
            frac_o        <= 6'd0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            idle_o        <= (state_d == S_IDLE);
            ref_rd_en_o   <= rd_en_d;
            ref_rd_addr_o <= addr_d;
            iss_end_q     <= iss_end_d;
            iss_fin_q     <= iss_fin_d;
            blk_start_o   <= blk_d;
            if (accept) begin
                dual_q <= (pos_x_i[2:0] >= 3'd2);
                off_q  <= pos_x_i[2:0];
                frac_o <= frac_i;
            end
        end
    end

    // Alignment window: {word0, word1}, pixel 0 of each word at the MSBs.
    always_comb begin
        w0    = dual_q ? word0_q : ref_rd_data_i;
        w1    = dual_q ? ref_rd_data_i : '0;
        cat   = '{default: '0};
        row_c = '{default: '0};
        for (int i = 0; i < int'(WORD_PIX); i++) begin
            cat[i]            = w0[(int'(WORD_PIX) - 1 - i) * int'(PIXEL_WIDTH) +: PIXEL_WIDTH];
            cat[i + int'(WORD_PIX)] = w1[(int'(WORD_PIX) - 1 - i) * int'(PIXEL_WIDTH) +: PIXEL_WIDTH];
        end
        for (int j = 0; j < int'(ROWS); j++) begin
            row_c[j] = cat[4'(off_q) + 4'(j)];
        end
    end

    // Read-return stage: hold word0 in dual mode, emit the aligned row on the row's last word.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dat_vld_q     <= 1'b0;
            dat_end_q     <= 1'b0;
            dat_fin_q     <= 1'b0;
            word0_q       <= '0;
            refuv_valid_o <= 1'b0;
            done_o        <= 1'b0;
            refuv_p0_o    <= '0;
            refuv_p1_o    <= '0;
            refuv_p2_o    <= '0;
            refuv_p3_o    <= '0;
            refuv_p4_o    <= '0;
            refuv_p5_o    <= '0;
            refuv_p6_o    <= '0;
        end else begin
            dat_vld_q     <= ref_rd_en_o;
            dat_end_q     <= ref_rd_en_o & iss_end_q;
            dat_fin_q     <= ref_rd_en_o & iss_fin_q;
            refuv_valid_o <= 1'b0;
            done_o        <= 1'b0;
            if (dat_vld_q && !dat_end_q) begin
                word0_q <= ref_rd_data_i;
            end
            if (dat_end_q) begin
                refuv_valid_o <= 1'b1;
                done_o        <= dat_fin_q;
                refuv_p0_o    <= row_c[0];
                refuv_p1_o    <= row_c[1];
                refuv_p2_o    <= row_c[2];
                refuv_p3_o    <= row_c[3];
                refuv_p4_o    <= row_c[4];
                refuv_p5_o    <= row_c[5];
                refuv_p6_o    <= row_c[6];
            end
        end
    end

endmodule

// File: doc/mc_chroma_ref_fetch4x4.md
# mc_chroma_ref_fetch4x4

Upstream feeder for the 4x4 chroma fractional interpolator in the MC reconstruction path. For each block it reads the 7x7 integer reference region (4x4 output plus 3 rows/columns of 4-tap support) from the chroma reference window SRAM. It aligns the row to an arbitrary pixel column and streams 7 rows of 7 pixels to the interpolator, together with the block-start pulse and the latched fractional MV.

## Interface
Parameters:
- `PIXEL_WIDTH`, default `` `PIXEL_WIDTH `` from enc_defines.v: bits per pixel.
- `ROW_WORDS`, default 8: SRAM words per window row; the window is 64 pixels wide.
- `AW`, default 9: SRAM address width; the window is 64 rows.

Ports (name, direction, width, meaning):
- `clk`  in  1  clock; one clock domain.
- `rstn`  in  1  reset; synchronous, active-low.
- `start_i`  in  1  block request pulse; accepted only when `idle_o`=1, otherwise ignored.
- `pos_x_i`  in  6  column of the top-left reference pixel in the window; legal range 0..57.
- `pos_y_i`  in  6  row of the top-left reference pixel; legal range 0..57.
- `frac_i`  in  6  fractional MV, {fracy, fracx}; latched on accept.
- `idle_o`  out  1  ready for a new block.
- `ref_rd_en_o`  out  1  SRAM read strobe.
- `ref_rd_addr_o`  out  AW  SRAM word address.
- `ref_rd_data_i`  in  8*PIXEL_WIDTH  8 pixels; pixel 0 is at the MSBs. Valid exactly 1 cycle after `ref_rd_en_o`.
- `blk_start_o`  out  1  one-cycle pulse preceding the block's first row.
- `refuv_valid_o`  out  1  row valid.
- `refuv_p0_o`..`refuv_p6_o`  out  PIXEL_WIDTH each  aligned row pixels, left to right.
- `frac_o`  out  6  latched `frac_i`.
- `done_o`  out  1  pulse coincident with the 7th valid row.

## Operation
- Accept: a start is accepted when `start_i` & `idle_o`. On accept the block latches `pos_x_i`, `pos_y_i` and `frac_i`, and `idle_o` drops.
- Offset: off = `pos_x_i`[2:0]. Base word wb = `pos_x_i`[5:3].
- Single mode (off ≤ 1): one read per row, address = (`pos_y_i`+r)*ROW_WORDS + wb.
- Dual mode (off ≥ 2): two reads per row, wb then wb+1. The legal position range guarantees wb+1 < ROW_WORDS.
- Alignment: concatenate {word0, word1} into 16 pixels, with word1 taken as 0 in single mode. Output pixel pj = concatenated pixel (off+j), for j = 0..6.
- Rows r = 0..6 are issued in order, back-to-back, with no idle cycles between rows.
- FSM states:
  - IDLE: → FETCH0 on accept.
  - FETCH0: issues word0. Goes to FETCH1 in dual mode. In single mode it stays in FETCH0 for the next row, or goes to DRAIN after row 6.
  - FETCH1: issues word1. Goes to FETCH0 for the next row, or to DRAIN after row 6.
  - DRAIN: waits until the last row is output, then → IDLE.
- Arithmetic: the address is computed in AW bits with no wrap; the legal range never overflows.
- Outputs are registered:
  - `refuv_valid_o` rises 2 cycles after the row's last read issue.
  - The pixel outputs hold their value between valid rows.
- `frac_o` is stable from the cycle after accept until the next accept.
- A start during a busy block is dropped; no queuing.
- Reset mid-block: the block returns to IDLE, all outputs take their reset values, and in-flight read data is discarded.
- Reset values: `idle_o`=1; every other output =0, including the pixel outputs, `frac_o` and `ref_rd_addr_o`.

## Timing
- Accept occurs at cycle s.
- `blk_start_o` and the first `ref_rd_en_o` both occur at s+1.
- Single mode:
  - Reads at s+1..s+7.
  - `refuv_valid_o` at s+3..s+9, consecutive.
  - `done_o` at s+9.
- Dual mode:
  - Reads at s+1..s+14.
  - `refuv_valid_o` at s+4, s+6, …, s+16.
  - `done_o` at s+16.
- `idle_o` returns to 1 the cycle after `done_o`. A new start is accepted in that cycle, so for back-to-back blocks `blk_start_o` follows 2 cycles after the previous `done_o`.
- `ref_rd_en_o` is low in IDLE and DRAIN.

## Test plan
- SRAM pixel (x,y) = (x+3y) mod 256 for all tests.
- Aligned block: x=8, y=0, frac=6'o35.
  - Reads at addresses 1, 9, …, 49.
  - 7 consecutive valid rows; row r = 8+3r .. 14+3r.
  - `frac_o`=6'o35; `done_o` at s+9.
- Dual mode: x=13, y=2.
  - Row 0 reads addresses 17 then 18; row 0 pixels = 19..25.
  - Valid every other cycle; `done_o` at s+16.
- Corner: x=57, y=57.
  - Single mode; last read address = 63*8+7 = 511.
  - Row 6 pixels = (57+189..63+189) mod 256 = 246..252.
- `start_i` held high throughout a dual block.
  - Exactly one block is run.
  - A second block is accepted on the cycle after `done_o`, with `blk_start_o` 2 cycles after `done_o`.
- `rstn`=0 asserted at s+5 of a dual block.
  - Next cycle: `idle_o`=1, `refuv_valid_o`=0, `ref_rd_en_o`=0, `done_o` never asserted.
  - A new start after reset produces a correct block.
